// File: rtl/cpu_pkg.sv
// Shared fetch/decode constants: instruction width, opcode field bounds, HALT opcode, fetch FSM states.
package cpu_pkg;
  localparam int INST_W = 32;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 21;
  localparam int OPC_W  = OPC_HI - OPC_LO + 1;

  localparam logic [OPC_W-1:0] OPC_HALT = 11'b11111111111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    ISSUE,
    HALTED
  } fetch_state_t;

  function automatic logic is_halt(input logic [INST_W-1:0] word);
    return word[OPC_HI:OPC_LO] == OPC_HALT;
  endfunction
endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch-stage bus: imem req/ack on one side, decode valid/ready plus branch redirect on the other.
interface cpu_fetch_if #(
  parameter int ADDR_W = 64
);
  import cpu_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;

  logic [INST_W-1:0] inst;
  logic [OPC_W-1:0]  inst31_21;
  logic [ADDR_W-1:0] pc;
  logic              inst_valid;
  logic              inst_ready;
  logic              br_taken;
  logic [ADDR_W-1:0] br_offset;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst, inst31_21, pc, inst_valid,
    input  inst_ready, br_taken, br_offset
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst, inst31_21, pc, inst_valid,
    output inst_ready, br_taken, br_offset
  );
endinterface

// File: rtl/cpu_pc_next.sv
// Combinational next-PC select: pc+4 or pc + (br_offset << 2), both modulo 2^ADDR_W.
// Zero latency; no handshake.
module cpu_pc_next #(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc_next
);
  always_comb begin
    pc_next = br_taken ? pc + (br_offset << 2) : pc + ADDR_W'(4);
  end
endmodule

// File: rtl/cpu_fetch.sv
// LEGv8 fetch stage: req/ack fetch into a one-entry holding register, valid/ready issue; 1 cycle req->valid, 1 instr/2 cycles max.
// Holds imem_addr until ack and inst/pc until ready; HALT stops forever. FETCH_PERF_EN adds issue/stall counters.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic       clk,
  input  logic       rst,
  cpu_fetch_if.master bus,
  input  logic       start,
  output logic       halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam logic [ADDR_W-1:0] PC_RST = RESET_PC & ~ADDR_W'(3);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc_q, pc_nxt;
  logic [INST_W-1:0] inst_q;
  logic              accept;
  logic              halt_op;

  assign accept  = (state == ISSUE) && bus.inst_ready;
  assign halt_op = is_halt(inst_q);

  cpu_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc       (pc_q),
    .br_taken (bus.br_taken),
    .br_offset(bus.br_offset),
    .pc_next  (pc_nxt)
  );

  always_comb begin
    state_nxt      = state;
    bus.imem_req   = 1'b0;
    bus.inst_valid = 1'b0;
    halted         = 1'b0;
    case (state)
      IDLE:   if (start) state_nxt = FETCH;
      FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.inst_valid = 1'b1;
        if (accept) state_nxt = halt_op ? HALTED : FETCH;
      end
      HALTED: halted = 1'b1;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc_q   <= PC_RST;
      inst_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && bus.imem_ack) inst_q <= bus.imem_rdata;
      // HALT wins over a simultaneous redirect: pc stays on the HALT word.
      if (accept && !halt_op) pc_q <= pc_nxt;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.pc        = pc_q;
  assign bus.inst      = inst_q;
  assign bus.inst31_21 = inst_q[OPC_HI:OPC_LO];

`ifdef FETCH_PERF_EN
  logic stall;
  assign stall = ((state == FETCH) && !bus.imem_ack) || ((state == ISSUE) && !bus.inst_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept && perf_issue_cnt != 32'hFFFF_FFFF) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (stall  && perf_stall_cnt != 32'hFFFF_FFFF) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cpu_fetch.sv
// Directed plus randomized bench for cpu_fetch; expected PCs come from plain modulo-2^64 arithmetic.
module tb_cpu_fetch;
  localparam int AW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic halted;
  always #5 clk = ~clk;

  cpu_fetch_if #(.ADDR_W(AW)) bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

  cpu_fetch #(.ADDR_W(AW), .RESET_PC(64'd0)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .start (start),
    .halted(halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_issue_cnt(perf_issue_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int exp_issue = 0;
  int exp_stall = 0;
  logic [63:0] exp_pc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_1234;
    if (w[31:21] == 11'h7FF) w[21] = 1'b0;
    return w;
  endfunction

  function automatic logic [63:0] next_pc(input logic [63:0] p, input logic tk, input logic [63:0] off);
    return tk ? p + off * 64'd4 : p + 64'd4;
  endfunction

  task automatic set_idle();
    start          = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.inst_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.br_offset  = 64'h0;
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    chk({tag, ":perf_issue"}, 64'(perf_issue_cnt), 64'(exp_issue));
    chk({tag, ":perf_stall"}, 64'(perf_stall_cnt), 64'(exp_stall));
`endif
  endtask

  // Reset with every other input asserted to show rst overrides them.
  task automatic do_reset(input string tag);
    rst            = 1'b1;
    start          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    bus.inst_ready = 1'b1;
    bus.br_taken   = 1'b1;
    tick();
    rst = 1'b0;
    set_idle();
    exp_issue = 0;
    exp_stall = 0;
    chk({tag, ":rst_req"},    64'(bus.imem_req),   64'd0);
    chk({tag, ":rst_valid"},  64'(bus.inst_valid), 64'd0);
    chk({tag, ":rst_inst"},   64'(bus.inst),       64'd0);
    chk({tag, ":rst_halted"}, 64'(halted),         64'd0);
    chk({tag, ":rst_pc"},     bus.pc,              64'd0);
    chk({tag, ":rst_addr"},   bus.imem_addr,       64'd0);
    check_perf({tag, ":rst"});
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, ":start_req"}, 64'(bus.imem_req), 64'd1);
  endtask

  // Entered in FETCH; leaves one cycle after the accept edge.
  task automatic issue_one(input string tag, input logic [63:0] p, input logic [31:0] word,
                           input int ack_dly, input int rdy_dly, input logic tk, input logic [63:0] off);
    chk({tag, ":req"},  64'(bus.imem_req), 64'd1);
    chk({tag, ":addr"}, bus.imem_addr,     p);
    for (int i = 0; i < ack_dly; i++) begin
      bus.imem_ack   = 1'b0;
      bus.inst_ready = 1'($urandom_range(0, 1));
      bus.br_taken   = 1'($urandom_range(0, 1));
      bus.br_offset  = {$urandom, $urandom};
      tick();
      chk({tag, ":wait_addr"},  bus.imem_addr,       p);
      chk({tag, ":wait_valid"}, 64'(bus.inst_valid), 64'd0);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    chk({tag, ":valid"}, 64'(bus.inst_valid), 64'd1);
    chk({tag, ":req0"},  64'(bus.imem_req),   64'd0);
    chk({tag, ":inst"},  64'(bus.inst),       64'(word));
    chk({tag, ":opc"},   64'(bus.inst31_21),  64'(word[31:21]));
    chk({tag, ":pc"},    bus.pc,              p);
    for (int i = 0; i < rdy_dly; i++) begin
      bus.inst_ready = 1'b0;
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.br_taken   = 1'($urandom_range(0, 1));
      tick();
      chk({tag, ":hold_inst"},  64'(bus.inst),       64'(word));
      chk({tag, ":hold_valid"}, 64'(bus.inst_valid), 64'd1);
      chk({tag, ":hold_pc"},    bus.pc,              p);
    end
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b1;
    bus.br_taken   = tk;
    bus.br_offset  = off;
    tick();
    set_idle();
    exp_issue += 1;
    exp_stall += ack_dly + rdy_dly;
    check_perf(tag);
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    tick();

    // Zero-wait memory: req on cycle 1, valid on 2/4/6, addresses 0, 4, 8.
    do_reset("zw");
    chk("zw:idle_req", 64'(bus.imem_req), 64'd0);
    do_start("zw");
    exp_pc = 64'd0;
    for (int k = 0; k < 3; k++) begin
      issue_one("zw", exp_pc, mem_word(exp_pc), 0, 0, 1'b0, 64'd0);
      exp_pc = next_pc(exp_pc, 1'b0, 64'd0);
    end
    chk("zw:addr12", bus.imem_addr, 64'd12);

    // Ack after 3 cycles, ready low for 2: five stall cycles.
    do_reset("stall");
    do_start("stall");
    issue_one("stall", 64'd0, mem_word(64'd0), 3, 2, 1'b0, 64'd0);
`ifdef FETCH_PERF_EN
    chk("stall:perf5", 64'(perf_stall_cnt), 64'd5);
`endif
    chk("stall:next_addr", bus.imem_addr, 64'd4);

    // Branch redirects around 0x40, then wrap at the top of the address space.
    do_reset("br");
    do_start("br");
    issue_one("br", 64'd0,    mem_word(64'd0),    0, 0, 1'b1, 64'd16);
    issue_one("br", 64'h40,   mem_word(64'h40),   1, 0, 1'b1, -64'sd4);
    chk("br:minus4", bus.imem_addr, 64'h30);
    issue_one("br", 64'h30,   mem_word(64'h30),   0, 1, 1'b1, 64'd4);
    issue_one("br", 64'h40,   mem_word(64'h40),   0, 0, 1'b1, 64'd3);
    chk("br:plus3", bus.imem_addr, 64'h4C);
    issue_one("wrap", 64'h4C, mem_word(64'h4C),   0, 0, 1'b1, -64'sd20);
    chk("wrap:top", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    issue_one("wrap", 64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 0, 0, 1'b0, 64'd0);
    chk("wrap:seq0", bus.imem_addr, 64'd0);
    issue_one("wrap", 64'd0, mem_word(64'd0), 0, 0, 1'b1, -64'sd1);
    issue_one("wrap", 64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC), 2, 0, 1'b1, 64'd2);
    chk("wrap:br4", bus.imem_addr, 64'd4);

    // HALT accepted together with a taken branch.
    issue_one("halt", 64'd4, 32'hFFE0_0000, 0, 1, 1'b1, 64'd5);
    for (int i = 0; i < 6; i++) begin
      start          = 1'($urandom_range(0, 1));
      bus.imem_ack   = 1'b1;
      bus.inst_ready = 1'b1;
      bus.br_taken   = 1'b1;
      bus.br_offset  = 64'd7;
      chk("halt:halted", 64'(halted),         64'd1);
      chk("halt:req",    64'(bus.imem_req),   64'd0);
      chk("halt:valid",  64'(bus.inst_valid), 64'd0);
      chk("halt:pc",     bus.pc,              64'd4);
      tick();
    end
    set_idle();
    check_perf("halt");

    // Reset out of HALTED, then reset during FETCH with ack present.
    do_reset("rst_halt");
    do_start("rst_fetch");
    bus.imem_ack = 1'b0;
    tick();
    do_reset("rst_fetch");
    do_start("refetch");
    issue_one("refetch", 64'd0, mem_word(64'd0), 1, 0, 1'b0, 64'd0);
    chk("refetch:addr", bus.imem_addr, 64'd4);

    // Randomized traffic against the arithmetic PC model.
    do_reset("rnd");
    do_start("rnd");
    exp_pc = 64'd0;
    for (int n = 0; n < 150; n++) begin
      logic        tk;
      logic [63:0] off;
      int          o;
      tk = 1'($urandom_range(0, 1));
      o  = int'($urandom_range(0, 128)) - 64;
      off = 64'(o);
      if ($urandom_range(0, 7) == 0) off = {$urandom, $urandom};
      issue_one("rnd", exp_pc, mem_word(exp_pc),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), tk, off);
      exp_pc = next_pc(exp_pc, tk, off);
    end
    chk("rnd:final_addr", bus.imem_addr, exp_pc);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
